// File: rtl/ctrl_pipe_if.sv
// Control-bundle interface between ID-stage decode and the pipeline control block.
// master drives decoded ID fields and the EX zero flag; slave returns hazard, flush and stage controls.
interface ctrl_pipe_if #(
  parameter int RA_W = 5
);
  logic            id_reg_dst;
  logic            id_reg_write;
  logic            id_alu_src;
  logic            id_mem_write;
  logic            id_mem_to_reg;
  logic            id_beq;
  logic            id_bne;
  logic            id_j;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic [RA_W-1:0] id_rd;
  logic            ex_zero;

  logic            hold_pc;
  logic            flush_if_id;
  logic            jump_taken;
  logic            branch_taken;
  logic            ex_alu_src;
  logic            ex_beq;
  logic            ex_bne;
  logic [RA_W-1:0] ex_rs;
  logic [RA_W-1:0] ex_rt;
  logic [RA_W-1:0] ex_dst;
  logic            mem_mem_write;
  logic            mem_mem_to_reg;
  logic            mem_reg_write;
  logic [RA_W-1:0] mem_dst;
  logic            wb_reg_write;
  logic            wb_mem_to_reg;
  logic [RA_W-1:0] wb_dst;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;

  modport master (
    output id_reg_dst, id_reg_write, id_alu_src, id_mem_write, id_mem_to_reg,
           id_beq, id_bne, id_j, id_rs, id_rt, id_rd, ex_zero,
    input  hold_pc, flush_if_id, jump_taken, branch_taken,
           ex_alu_src, ex_beq, ex_bne, ex_rs, ex_rt, ex_dst,
           mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_dst,
           wb_reg_write, wb_mem_to_reg, wb_dst, fwd_a, fwd_b
  );

  modport slave (
    input  id_reg_dst, id_reg_write, id_alu_src, id_mem_write, id_mem_to_reg,
           id_beq, id_bne, id_j, id_rs, id_rt, id_rd, ex_zero,
    output hold_pc, flush_if_id, jump_taken, branch_taken,
           ex_alu_src, ex_beq, ex_bne, ex_rs, ex_rt, ex_dst,
           mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_dst,
           wb_reg_write, wb_mem_to_reg, wb_dst, fwd_a, fwd_b
  );
endinterface

// File: rtl/ctrl_pipe.sv
// MIPS 5-stage control pipeline: ID/EX, EX/MEM, MEM/WB control registers, branch/jump resolve,
// load-use stall with bubble insertion and EX operand forwarding selects. Only ID/EX ever bubbles.
module ctrl_pipe #(
  parameter int RA_W   = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  ctrl_pipe_if.slave   bus
);
  typedef logic [RA_W-1:0] ra_t;

  // ID/EX
  logic ex_reg_write_q, ex_mem_write_q, ex_mem_to_reg_q, ex_alu_src_q, ex_beq_q, ex_bne_q;
  ra_t  ex_rs_q, ex_rt_q, ex_dst_q;
  // EX/MEM
  logic mem_reg_write_q, mem_mem_write_q, mem_mem_to_reg_q;
  ra_t  mem_dst_q;
  // MEM/WB
  logic wb_reg_write_q, wb_mem_to_reg_q;
  ra_t  wb_dst_q;

  logic branch_taken, load_use, hold_pc, jump_taken;
  ra_t  id_dst;

  assign id_dst       = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
  assign branch_taken = (ex_beq_q & bus.ex_zero) | (ex_bne_q & ~bus.ex_zero);
  assign load_use     = ex_mem_to_reg_q & ex_reg_write_q &
                        ((ex_dst_q == bus.id_rs) | (ex_dst_q == bus.id_rt));
  // A taken branch squashes the stalled instruction anyway, so it overrides the stall.
  assign hold_pc      = load_use & ~branch_taken;
  assign jump_taken   = bus.id_j & ~hold_pc & ~branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_reg_write_q  <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_mem_to_reg_q <= 1'b0;
      ex_alu_src_q    <= 1'b0;
      ex_beq_q        <= 1'b0;
      ex_bne_q        <= 1'b0;
      ex_rs_q         <= '0;
      ex_rt_q         <= '0;
      ex_dst_q        <= '0;
    end else if (branch_taken || hold_pc) begin
      ex_reg_write_q  <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_mem_to_reg_q <= 1'b0;
      ex_alu_src_q    <= 1'b0;
      ex_beq_q        <= 1'b0;
      ex_bne_q        <= 1'b0;
      ex_rs_q         <= '0;
      ex_rt_q         <= '0;
      ex_dst_q        <= '0;
    end else begin
      // Writes to $zero are dropped here so no later stage ever forwards or stalls on r0.
      ex_reg_write_q  <= bus.id_reg_write & (id_dst != '0);
      ex_mem_write_q  <= bus.id_mem_write;
      ex_mem_to_reg_q <= bus.id_mem_to_reg;
      ex_alu_src_q    <= bus.id_alu_src;
      ex_beq_q        <= bus.id_beq;
      ex_bne_q        <= bus.id_bne;
      ex_rs_q         <= bus.id_rs;
      ex_rt_q         <= bus.id_rt;
      ex_dst_q        <= id_dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_reg_write_q  <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_mem_to_reg_q <= 1'b0;
      mem_dst_q        <= '0;
      wb_reg_write_q   <= 1'b0;
      wb_mem_to_reg_q  <= 1'b0;
      wb_dst_q         <= '0;
    end else begin
      mem_reg_write_q  <= ex_reg_write_q;
      mem_mem_write_q  <= ex_mem_write_q;
      mem_mem_to_reg_q <= ex_mem_to_reg_q;
      mem_dst_q        <= ex_dst_q;
      wb_reg_write_q   <= mem_reg_write_q;
      wb_mem_to_reg_q  <= mem_mem_to_reg_q;
      wb_dst_q         <= mem_dst_q;
    end
  end

  function automatic logic [1:0] fwd_sel(input ra_t src);
    if (mem_reg_write_q && (mem_dst_q != '0) && (mem_dst_q == src)) return 2'b10;
    if (wb_reg_write_q && (wb_dst_q != '0) && (wb_dst_q == src))    return 2'b01;
    return 2'b00;
  endfunction

  if (FWD_EN) begin : g_fwd
    assign bus.fwd_a = fwd_sel(ex_rs_q);
    assign bus.fwd_b = fwd_sel(ex_rt_q);
  end else begin : g_no_fwd
    assign bus.fwd_a = 2'b00;
    assign bus.fwd_b = 2'b00;
  end

  assign bus.hold_pc        = hold_pc;
  assign bus.branch_taken   = branch_taken;
  assign bus.jump_taken     = jump_taken;
  assign bus.flush_if_id    = branch_taken | jump_taken;
  assign bus.ex_alu_src     = ex_alu_src_q;
  assign bus.ex_beq         = ex_beq_q;
  assign bus.ex_bne         = ex_bne_q;
  assign bus.ex_rs          = ex_rs_q;
  assign bus.ex_rt          = ex_rt_q;
  assign bus.ex_dst         = ex_dst_q;
  assign bus.mem_mem_write  = mem_mem_write_q;
  assign bus.mem_mem_to_reg = mem_mem_to_reg_q;
  assign bus.mem_reg_write  = mem_reg_write_q;
  assign bus.mem_dst        = mem_dst_q;
  assign bus.wb_reg_write   = wb_reg_write_q;
  assign bus.wb_mem_to_reg  = wb_mem_to_reg_q;
  assign bus.wb_dst         = wb_dst_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed pipeline scenarios plus randomized traffic against an
// instruction-level model that tracks which instruction occupies EX, MEM and WB.
module tb_ctrl_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ctrl_pipe_if #(.RA_W(5)) bus ();
  ctrl_pipe #(.RA_W(5), .FWD_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [40:0] all_outs;
  assign all_outs = {bus.hold_pc, bus.flush_if_id, bus.jump_taken, bus.branch_taken,
                     bus.ex_alu_src, bus.ex_beq, bus.ex_bne, bus.ex_rs, bus.ex_rt, bus.ex_dst,
                     bus.mem_mem_write, bus.mem_mem_to_reg, bus.mem_reg_write, bus.mem_dst,
                     bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_dst, bus.fwd_a, bus.fwd_b};

  // Instruction-level model: occupant[0] is in EX, [1] in MEM, [2] in WB.
  typedef struct packed {
    logic       rw, alu, mw, m2r, beq, bne;
    logic [4:0] rs, rt, dst;
  } ins_t;
  ins_t occupant [3];

  function automatic logic m_branch();
    return (occupant[0].beq && bus.ex_zero) || (occupant[0].bne && !bus.ex_zero);
  endfunction

  function automatic logic m_hold();
    ins_t e = occupant[0];
    logic reads_load = e.m2r && e.rw && (e.dst == bus.id_rs || e.dst == bus.id_rt);
    return reads_load && !m_branch();
  endfunction

  function automatic logic m_jump();
    return bus.id_j && !m_hold() && !m_branch();
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (src != 0 && occupant[1].rw && occupant[1].dst == src) return 2'b10;
    if (src != 0 && occupant[2].rw && occupant[2].dst == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [40:0] m_outs();
    return {m_hold(), m_branch() || m_jump(), m_jump(), m_branch(),
            occupant[0].alu, occupant[0].beq, occupant[0].bne,
            occupant[0].rs, occupant[0].rt, occupant[0].dst,
            occupant[1].mw, occupant[1].m2r, occupant[1].rw, occupant[1].dst,
            occupant[2].rw, occupant[2].m2r, occupant[2].dst,
            m_fwd(occupant[0].rs), m_fwd(occupant[0].rt)};
  endfunction

  function automatic ins_t m_decode();
    ins_t d;
    d.dst = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
    d.rw  = bus.id_reg_write && d.dst != 0;
    d.alu = bus.id_alu_src;
    d.mw  = bus.id_mem_write;
    d.m2r = bus.id_mem_to_reg;
    d.beq = bus.id_beq;
    d.bne = bus.id_bne;
    d.rs  = bus.id_rs;
    d.rt  = bus.id_rt;
    return d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupant[0] = '0;
      occupant[1] = '0;
      occupant[2] = '0;
    end else begin
      ins_t entering;
      entering = (m_branch() || m_hold()) ? ins_t'('0) : m_decode();
      occupant[2] = occupant[1];
      occupant[1] = occupant[0];
      occupant[0] = entering;
    end
  end

  task automatic set_id(input logic rdst, rw, alu, mw, m2r, beq, bne, j,
                        input logic [4:0] rs, rt, rd);
    bus.id_reg_dst    = rdst;
    bus.id_reg_write  = rw;
    bus.id_alu_src    = alu;
    bus.id_mem_write  = mw;
    bus.id_mem_to_reg = m2r;
    bus.id_beq        = beq;
    bus.id_bne        = bne;
    bus.id_j          = j;
    bus.id_rs         = rs;
    bus.id_rt         = rt;
    bus.id_rd         = rd;
    #1;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    bus.ex_zero = 1'b0;
    nop();
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (all_outs !== 41'd0) begin
      n_fail++; $display("FAIL reset_held: outputs=%h expected 0", all_outs);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_checks++;
    if (all_outs !== 41'd0) begin
      n_fail++; $display("FAIL reset_first_cycle: outputs=%h expected 0", all_outs);
    end
  endtask

  task automatic test_rtype_latency();
    set_id(1, 1, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    tick(); nop();
    n_checks++;
    if (bus.ex_dst !== 5'd3) begin
      n_fail++; $display("FAIL rtype_ex_dst: got %0d expected 3", bus.ex_dst);
    end
    tick();
    n_checks++;
    if ({bus.mem_reg_write, bus.mem_dst} !== {1'b1, 5'd3}) begin
      n_fail++; $display("FAIL rtype_mem: got rw=%b dst=%0d expected rw=1 dst=3",
                         bus.mem_reg_write, bus.mem_dst);
    end
    tick();
    n_checks++;
    if ({bus.wb_reg_write, bus.wb_dst} !== {1'b1, 5'd3}) begin
      n_fail++; $display("FAIL rtype_wb: got rw=%b dst=%0d expected rw=1 dst=3",
                         bus.wb_reg_write, bus.wb_dst);
    end
    drain();
  endtask

  task automatic test_raw_forwarding();
    set_id(1, 1, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd5);
    tick(); set_id(1, 1, 0, 0, 0, 0, 0, 0, 5'd5, 5'd6, 5'd7);
    tick(); nop();
    n_checks++;
    if ({bus.fwd_a, bus.fwd_b} !== 4'b1000) begin
      n_fail++; $display("FAIL raw_exmem: fwd_a=%b fwd_b=%b expected 10/00", bus.fwd_a, bus.fwd_b);
    end
    drain();
    set_id(1, 1, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd5);
    tick(); set_id(1, 1, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd8);
    tick(); set_id(1, 1, 0, 0, 0, 0, 0, 0, 5'd5, 5'd6, 5'd9);
    tick(); nop();
    n_checks++;
    if (bus.fwd_a !== 2'b01) begin
      n_fail++; $display("FAIL raw_memwb: fwd_a=%b expected 01", bus.fwd_a);
    end
    drain();
    set_id(1, 1, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd0);
    tick(); set_id(1, 1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd6, 5'd7);
    tick(); nop();
    n_checks++;
    if (bus.fwd_a !== 2'b00) begin
      n_fail++; $display("FAIL raw_r0: fwd_a=%b expected 00", bus.fwd_a);
    end
    drain();
  endtask

  task automatic test_load_use();
    set_id(0, 1, 1, 0, 1, 0, 0, 0, 5'd1, 5'd7, 5'd0);
    tick(); set_id(1, 1, 0, 0, 0, 0, 0, 0, 5'd7, 5'd2, 5'd4);
    n_checks++;
    if ({bus.hold_pc, bus.flush_if_id} !== 2'b10) begin
      n_fail++; $display("FAIL lu_stall: hold=%b flush=%b expected 1/0", bus.hold_pc, bus.flush_if_id);
    end
    tick();
    n_checks++;
    if ({bus.hold_pc, bus.ex_dst, bus.ex_rs, bus.mem_mem_to_reg} !== {1'b0, 5'd0, 5'd0, 1'b1}) begin
      n_fail++; $display("FAIL lu_bubble: hold=%b ex_dst=%0d ex_rs=%0d mem_m2r=%b expected 0/0/0/1",
                         bus.hold_pc, bus.ex_dst, bus.ex_rs, bus.mem_mem_to_reg);
    end
    tick(); nop();
    n_checks++;
    if ({bus.fwd_a, bus.ex_rs} !== {2'b01, 5'd7}) begin
      n_fail++; $display("FAIL lu_fwd: fwd_a=%b ex_rs=%0d expected 01/7", bus.fwd_a, bus.ex_rs);
    end
    drain();
    // Jump stalled behind a load-use waits one cycle.
    set_id(0, 1, 1, 0, 1, 0, 0, 0, 5'd1, 5'd7, 5'd0);
    tick(); set_id(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd0, 5'd0);
    n_checks++;
    if ({bus.hold_pc, bus.jump_taken} !== 2'b10) begin
      n_fail++; $display("FAIL jump_stalled: hold=%b jump=%b expected 1/0", bus.hold_pc, bus.jump_taken);
    end
    tick();
    n_checks++;
    if ({bus.hold_pc, bus.jump_taken, bus.flush_if_id} !== 3'b011) begin
      n_fail++; $display("FAIL jump_released: hold=%b jump=%b flush=%b expected 0/1/1",
                         bus.hold_pc, bus.jump_taken, bus.flush_if_id);
    end
    drain();
  endtask

  task automatic test_branch_jump();
    set_id(0, 0, 0, 0, 0, 1, 0, 0, 5'd1, 5'd2, 5'd0);
    tick(); set_id(1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd9, 5'd9);
    bus.ex_zero = 1'b1; #1;
    n_checks++;
    if ({bus.branch_taken, bus.flush_if_id, bus.jump_taken} !== 3'b110) begin
      n_fail++; $display("FAIL beq_vs_j: br=%b flush=%b jump=%b expected 1/1/0",
                         bus.branch_taken, bus.flush_if_id, bus.jump_taken);
    end
    tick();
    n_checks++;
    if ({bus.ex_beq, bus.ex_dst, bus.ex_rt} !== {1'b0, 5'd0, 5'd0}) begin
      n_fail++; $display("FAIL beq_bubble: ex_beq=%b ex_dst=%0d ex_rt=%0d expected 0/0/0",
                         bus.ex_beq, bus.ex_dst, bus.ex_rt);
    end
    bus.ex_zero = 1'b0;
    drain();
    set_id(0, 0, 0, 0, 0, 1, 0, 0, 5'd1, 5'd2, 5'd0);
    tick(); set_id(0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    n_checks++;
    if ({bus.branch_taken, bus.jump_taken, bus.flush_if_id} !== 3'b011) begin
      n_fail++; $display("FAIL beq_not_taken: br=%b jump=%b flush=%b expected 0/1/1",
                         bus.branch_taken, bus.jump_taken, bus.flush_if_id);
    end
    drain();
    set_id(0, 0, 0, 0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd0);
    tick(); nop();
    bus.ex_zero = 1'b0; #1;
    n_checks++;
    if (bus.branch_taken !== 1'b1) begin
      n_fail++; $display("FAIL bne_taken: br=%b expected 1", bus.branch_taken);
    end
    bus.ex_zero = 1'b1; #1;
    n_checks++;
    if (bus.branch_taken !== 1'b0) begin
      n_fail++; $display("FAIL bne_not_taken: br=%b expected 0", bus.branch_taken);
    end
    bus.ex_zero = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid_stall();
    set_id(0, 1, 1, 0, 1, 0, 0, 0, 5'd1, 5'd7, 5'd0);
    tick(); set_id(1, 1, 0, 0, 0, 0, 0, 0, 5'd7, 5'd2, 5'd4);
    n_checks++;
    if (bus.hold_pc !== 1'b1) begin
      n_fail++; $display("FAIL mid_stall_setup: hold=%b expected 1", bus.hold_pc);
    end
    rst_n = 1'b0; #1;
    n_checks++;
    if (all_outs !== 41'd0) begin
      n_fail++; $display("FAIL mid_stall_async: outputs=%h expected 0", all_outs);
    end
    @(posedge clk); #1 rst_n = 1'b1; #1;
    n_checks++;
    if (bus.hold_pc !== 1'b0) begin
      n_fail++; $display("FAIL mid_stall_stale: hold=%b expected 0", bus.hold_pc);
    end
    tick();
    n_checks++;
    if ({bus.ex_rs, bus.ex_dst} !== {5'd7, 5'd4}) begin
      n_fail++; $display("FAIL mid_stall_resume: ex_rs=%0d ex_dst=%0d expected 7/4", bus.ex_rs, bus.ex_dst);
    end
    drain();
  endtask

  task automatic test_random();
    logic [40:0] exp_outs;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.ex_zero = 1'($urandom_range(0, 1));
      set_id(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 5) == 0),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      exp_outs = m_outs();
      n_checks++;
      if (all_outs !== exp_outs) begin
        n_fail++; $display("FAIL random_cycle_%0d: outputs=%h expected %h", cyc, all_outs, exp_outs);
      end
      tick();
    end
    nop();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rtype_latency();
    test_raw_forwarding();
    test_load_use();
    test_branch_jump();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
